// File: rtl/gpio_io_pkg.sv
// Shared definitions for the LED/switch GPIO controller.
package gpio_io_pkg;

  // Colour index within one RGB LED triplet.
  typedef enum logic [1:0] {
    COLOR_R = 2'd0,
    COLOR_G = 2'd1,
    COLOR_B = 2'd2
  } color_e;

  localparam int unsigned NB_COLOR     = 3;
  localparam int unsigned NB_PWM_DEF   = 8;
  localparam int unsigned NB_PRESC_DEF = 16;

endpackage

// File: rtl/gpio_led_sw_ctrl_if.sv
// GPIO word / board pin bundle between the CPU side and the LED/switch controller.
interface gpio_led_sw_ctrl_if
  import gpio_io_pkg::*;
#(
  parameter int unsigned NB_CH    = 4,
  parameter int unsigned NB_PWM   = NB_PWM_DEF,
  parameter int unsigned NB_PRESC = NB_PRESC_DEF,
  parameter int unsigned NB_SW    = 4
);
  localparam int unsigned NB_LED = NB_COLOR * NB_CH;

  logic [NB_LED-1:0]        i_led_en;
  logic [NB_LED*NB_PWM-1:0] i_duty;
  logic [NB_PRESC-1:0]      i_prescale;
  logic [NB_SW-1:0]         i_sw;
  logic [NB_SW-1:0]         i_sw_vio;
  logic                     i_from_hard;
  logic [NB_LED-1:0]        out_leds_rgb;
  logic [NB_SW-1:0]         out_gpi;
  logic                     out_sw_change;

  modport master (
    output i_led_en, i_duty, i_prescale, i_sw, i_sw_vio, i_from_hard,
    input  out_leds_rgb, out_gpi, out_sw_change
  );

  modport slave (
    input  i_led_en, i_duty, i_prescale, i_sw, i_sw_vio, i_from_hard,
    output out_leds_rgb, out_gpi, out_sw_change
  );

endinterface

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a stable-count debouncer.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clock,
  input  logic in_reset,
  input  logic sw_raw,
  output logic sw_stable
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clock or negedge in_reset) begin
    if (!in_reset) sync_q <= 2'b00;
    else           sync_q <= {sync_q[0], sw_raw};
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock or negedge in_reset) begin
    if (!in_reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync_q[1] == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q    <= '0;
      stable_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sw_stable = stable_q;

endmodule

// File: rtl/gpio_led_sw_ctrl.sv
// RGB LED PWM driver plus debounced switch / VIO source select for the GPIO input word.
module gpio_led_sw_ctrl
  import gpio_io_pkg::*;
#(
  parameter int unsigned NB_CH           = 4,
  parameter int unsigned NB_PWM          = NB_PWM_DEF,
  parameter int unsigned NB_PRESC        = NB_PRESC_DEF,
  parameter int unsigned NB_SW           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input logic              clock,
  input logic              in_reset,
  gpio_led_sw_ctrl_if.slave bus
);
  localparam int unsigned NB_LED  = NB_COLOR * NB_CH;
  localparam int unsigned NB_DUTY = NB_LED * NB_PWM;

  logic [NB_PRESC-1:0] presc_cnt;
  logic                tick_c;
  logic [NB_PWM-1:0]   pwm_cnt;
  logic [NB_DUTY-1:0]  shadow_duty;
  logic [NB_LED-1:0]   led_next_c;
  logic [NB_LED-1:0]   leds_q;
  logic [NB_SW-1:0]    sw_stable;
  logic [NB_SW-1:0]    gpi_next_c;
  logic [NB_SW-1:0]    gpi_q;
  logic                sw_change_q;

  // Equality (not >=) lets an over-range count run to all-ones and wrap.
  assign tick_c = (presc_cnt == bus.i_prescale);

  // Prescaler: 0..i_prescale.
  always_ff @(posedge clock or negedge in_reset) begin
    if (!in_reset)   presc_cnt <= '0;
    else if (tick_c) presc_cnt <= '0;
    else             presc_cnt <= presc_cnt + NB_PRESC'(1);
  end

  // Free-running PWM phase counter advanced by the prescaler tick.
  always_ff @(posedge clock or negedge in_reset) begin
    if (!in_reset)   pwm_cnt <= '0;
    else if (tick_c) pwm_cnt <= pwm_cnt + NB_PWM'(1);
  end

  // Shadow duties reload only at the period wrap so a period is never cut short.
  always_ff @(posedge clock or negedge in_reset) begin
    if (!in_reset)                  shadow_duty <= '0;
    else if (tick_c && (&pwm_cnt))  shadow_duty <= bus.i_duty;
  end

  // Per-colour compare; all-ones duty forces a steady on.
  for (genvar j = 0; j < NB_LED; j++) begin : g_led
    logic [NB_PWM-1:0] duty;
    assign duty          = shadow_duty[j*NB_PWM +: NB_PWM];
    assign led_next_c[j] = bus.i_led_en[j] & ((&duty) | (pwm_cnt < duty));
  end

  // Registered LED drive.
  always_ff @(posedge clock or negedge in_reset) begin
    if (!in_reset) leds_q <= '0;
    else           leds_q <= led_next_c;
  end

  // One synchroniser/debouncer per switch.
  for (genvar b = 0; b < NB_SW; b++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
      .clock    (clock),
      .in_reset (in_reset),
      .sw_raw   (bus.i_sw[b]),
      .sw_stable(sw_stable[b])
    );
  end

  assign gpi_next_c = bus.i_from_hard ? sw_stable : bus.i_sw_vio;

  // GPI register and change pulse aligned with the first cycle of the new value.
  always_ff @(posedge clock or negedge in_reset) begin
    if (!in_reset) begin
      gpi_q       <= '0;
      sw_change_q <= 1'b0;
    end else begin
      gpi_q       <= gpi_next_c;
      sw_change_q <= (gpi_next_c != gpi_q);
    end
  end

  assign bus.out_leds_rgb  = leds_q;
  assign bus.out_gpi       = gpi_q;
  assign bus.out_sw_change = sw_change_q;

endmodule

// File: tb/tb_gpio_led_sw_ctrl.sv
// Self-checking bench for gpio_led_sw_ctrl: PWM duty windows, duty shadowing, prescale,
// debounce latency/rejection, source select and reset behaviour.
module tb_gpio_led_sw_ctrl;
  localparam int unsigned NB_CH    = 4;
  localparam int unsigned NB_PWM   = 4;
  localparam int unsigned NB_PRESC = 8;
  localparam int unsigned NB_SW    = 4;
  localparam int unsigned DEB      = 8;
  localparam int unsigned NB_LED   = 3 * NB_CH;
  localparam int unsigned PERIOD   = 1 << NB_PWM;
  // Edge count (first sampling edge = 1) on which a held switch level becomes visible.
  localparam int unsigned SW_LAT   = DEB + 3;

  logic clock = 1'b0;
  logic in_reset;
  int   total = 0;
  int   bad   = 0;
  int   hi_cnt [NB_LED];

  gpio_led_sw_ctrl_if #(
    .NB_CH(NB_CH), .NB_PWM(NB_PWM), .NB_PRESC(NB_PRESC), .NB_SW(NB_SW)
  ) bus ();

  gpio_led_sw_ctrl #(
    .NB_CH(NB_CH), .NB_PWM(NB_PWM), .NB_PRESC(NB_PRESC), .NB_SW(NB_SW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock   (clock),
    .in_reset(in_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_duty(input int j, input int unsigned d);
    bus.i_duty[j*NB_PWM +: NB_PWM] = NB_PWM'(d);
  endtask

  // High samples expected in a window of PERIOD*(p+1) cycles.
  function automatic int exp_high(input int unsigned d, input bit en, input int unsigned p);
    if (!en) return 0;
    return ((d == PERIOD - 1) ? int'(PERIOD) : int'(d)) * int'(p + 1);
  endfunction

  task automatic measure(input int n);
    for (int j = 0; j < NB_LED; j++) hi_cnt[j] = 0;
    repeat (n) begin
      step();
      for (int j = 0; j < NB_LED; j++) hi_cnt[j] += int'(bus.out_leds_rgb[j]);
    end
  endtask

  task automatic test_reset();
    logic [NB_LED-1:0] exp_led;
    logic [NB_SW-1:0]  exp_gpi;
    in_reset        = 1'b1;
    bus.i_led_en    = '1;
    bus.i_duty      = '1;
    bus.i_prescale  = '0;
    bus.i_sw        = 4'hF;
    bus.i_sw_vio    = 4'h0;
    bus.i_from_hard = 1'b1;
    step(); step();
    in_reset = 1'b0;
    #1;
    total++; if (bus.out_leds_rgb !== '0) begin bad++; $display("FAIL reset_leds got=%h want=0", bus.out_leds_rgb); end
    total++; if (bus.out_gpi !== '0) begin bad++; $display("FAIL reset_gpi got=%h want=0", bus.out_gpi); end
    total++; if (bus.out_sw_change !== 1'b0) begin bad++; $display("FAIL reset_change got=%b want=0", bus.out_sw_change); end
    step(); step();
    total++; if (bus.out_leds_rgb !== '0 || bus.out_gpi !== '0) begin
      bad++; $display("FAIL reset_held leds=%h gpi=%h want=0", bus.out_leds_rgb, bus.out_gpi);
    end
    in_reset = 1'b1;
    // Shadow duty stays 0 until the first wrap; switches need the full debounce latency.
    for (int n = 1; n <= 17; n++) begin
      step();
      exp_led = (n >= 17) ? '1 : '0;
      exp_gpi = (n >= int'(SW_LAT)) ? 4'hF : 4'h0;
      total++; if (bus.out_leds_rgb !== exp_led) begin bad++; $display("FAIL release_leds n=%0d got=%h want=%h", n, bus.out_leds_rgb, exp_led); end
      total++; if (bus.out_gpi !== exp_gpi) begin bad++; $display("FAIL release_gpi n=%0d got=%h want=%h", n, bus.out_gpi, exp_gpi); end
      total++; if (bus.out_sw_change !== (n == int'(SW_LAT))) begin bad++; $display("FAIL release_change n=%0d got=%b", n, bus.out_sw_change); end
    end
  endtask

  task automatic test_pwm();
    bus.i_led_en = '0;
    bus.i_led_en[2:0] = 3'b111;
    bus.i_duty = '0;
    set_duty(0, 4); set_duty(1, 0); set_duty(2, 15);
    repeat (2*PERIOD + 4) step();
    measure(PERIOD);
    total++; if (hi_cnt[0] != 4)  begin bad++; $display("FAIL pwm_red got=%0d want=4", hi_cnt[0]); end
    total++; if (hi_cnt[1] != 0)  begin bad++; $display("FAIL pwm_green got=%0d want=0", hi_cnt[1]); end
    total++; if (hi_cnt[2] != 16) begin bad++; $display("FAIL pwm_blue got=%0d want=16", hi_cnt[2]); end
    total++; if (hi_cnt[3] != 0)  begin bad++; $display("FAIL pwm_disabled got=%0d want=0", hi_cnt[3]); end
  endtask

  task automatic test_glitch_free();
    logic prev, cur;
    bit   found;
    int   h;
    found = 1'b0;
    prev  = bus.out_leds_rgb[0];
    for (int i = 0; i < int'(2*PERIOD); i++) begin
      step();
      cur = bus.out_leds_rgb[0];
      if (!prev && cur) begin found = 1'b1; break; end
      prev = cur;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL glitch_sync got=no_rise want=rise");
    end else begin
      // This sample is PWM count 0 of a period; write the new duty at count 2.
      h = 1;
      for (int i = 1; i < int'(PERIOD); i++) begin
        step();
        if (i == 1) set_duty(0, 12);
        h += int'(bus.out_leds_rgb[0]);
      end
      total++; if (h != 4) begin bad++; $display("FAIL glitch_current got=%0d want=4", h); end
      measure(PERIOD);
      total++; if (hi_cnt[0] != 12) begin bad++; $display("FAIL glitch_next got=%0d want=12", hi_cnt[0]); end
    end
    total++; if (bus.out_leds_rgb[2] !== 1'b1) begin bad++; $display("FAIL enable_before got=%b want=1", bus.out_leds_rgb[2]); end
    bus.i_led_en[2] = 1'b0;
    step();
    total++; if (bus.out_leds_rgb[2] !== 1'b0) begin bad++; $display("FAIL enable_clear got=%b want=0", bus.out_leds_rgb[2]); end
  endtask

  task automatic test_prescale();
    bus.i_prescale = NB_PRESC'(3);
    set_duty(0, 8);
    repeat (2*4*PERIOD + 8) step();
    measure(4*PERIOD);
    total++; if (hi_cnt[0] != 32) begin bad++; $display("FAIL prescale_high got=%0d want=32", hi_cnt[0]); end
  endtask

  task automatic test_prescale_lower();
    bus.i_prescale = NB_PRESC'(200);
    repeat (100) step();
    bus.i_prescale = '0;
    set_duty(0, 5);
    repeat (300) step();
    measure(PERIOD);
    total++; if (hi_cnt[0] != 5) begin bad++; $display("FAIL prescale_lower got=%0d want=5", hi_cnt[0]); end
  endtask

  task automatic test_random_pwm();
    int unsigned d [NB_LED];
    bit          en [NB_LED];
    int unsigned p;
    for (int it = 0; it < 3; it++) begin
      p = $urandom_range(0, 1);
      bus.i_prescale = NB_PRESC'(p);
      for (int j = 0; j < NB_LED; j++) begin
        d[j]  = $urandom_range(0, PERIOD - 1);
        en[j] = 1'($urandom_range(0, 3) != 0);
        set_duty(j, d[j]);
        bus.i_led_en[j] = en[j];
      end
      repeat (2*PERIOD*(p+1) + 4) step();
      measure(int'(PERIOD*(p+1)));
      for (int j = 0; j < NB_LED; j++) begin
        total++;
        if (hi_cnt[j] != exp_high(d[j], en[j], p)) begin
          bad++; $display("FAIL rand_pwm it=%0d ch=%0d got=%0d want=%0d", it, j, hi_cnt[j], exp_high(d[j], en[j], p));
        end
      end
    end
  endtask

  task automatic test_debounce();
    int pulses;
    int w, g, b;
    bus.i_from_hard = 1'b1;
    bus.i_sw = 4'h0;
    repeat (20) step();
    total++; if (bus.out_gpi !== 4'h0) begin bad++; $display("FAIL deb_settle got=%h want=0", bus.out_gpi); end
    pulses = 0;
    bus.i_sw[0] = 1'b1;
    repeat (5) begin step(); pulses += int'(bus.out_sw_change); end
    bus.i_sw[0] = 1'b0;
    repeat (30) begin step(); pulses += int'(bus.out_sw_change); end
    // Random bounces, each shorter than the debounce window.
    for (int it = 0; it < 8; it++) begin
      b = $urandom_range(0, NB_SW - 1);
      w = $urandom_range(1, DEB - 1);
      g = $urandom_range(1, 4);
      bus.i_sw[b] = 1'b1;
      repeat (w) begin step(); pulses += int'(bus.out_sw_change); end
      bus.i_sw[b] = 1'b0;
      repeat (g) begin step(); pulses += int'(bus.out_sw_change); end
    end
    repeat (20) begin step(); pulses += int'(bus.out_sw_change); end
    total++; if (pulses != 0) begin bad++; $display("FAIL bounce_pulses got=%0d want=0", pulses); end
    total++; if (bus.out_gpi !== 4'h0) begin bad++; $display("FAIL bounce_gpi got=%h want=0", bus.out_gpi); end
    bus.i_sw[0] = 1'b1;
    for (int n = 1; n <= int'(SW_LAT) + 1; n++) begin
      step();
      total++; if (bus.out_gpi !== ((n >= int'(SW_LAT)) ? 4'h1 : 4'h0)) begin bad++; $display("FAIL deb_latency n=%0d got=%h", n, bus.out_gpi); end
      total++; if (bus.out_sw_change !== (n == int'(SW_LAT))) begin bad++; $display("FAIL deb_pulse n=%0d got=%b", n, bus.out_sw_change); end
    end
    repeat (8) step();
  endtask

  task automatic test_source_select();
    int pulses;
    bus.i_from_hard = 1'b0;
    bus.i_sw_vio    = 4'hA;
    step();
    total++; if (bus.out_gpi !== 4'hA) begin bad++; $display("FAIL vio_value got=%h want=a", bus.out_gpi); end
    total++; if (bus.out_sw_change !== 1'b1) begin bad++; $display("FAIL vio_pulse got=%b want=1", bus.out_sw_change); end
    step();
    total++; if (bus.out_sw_change !== 1'b0) begin bad++; $display("FAIL vio_pulse_end got=%b want=0", bus.out_sw_change); end
    pulses = 0;
    bus.i_sw = 4'hA;
    repeat (20) begin step(); pulses += int'(bus.out_sw_change); end
    total++; if (pulses != 0) begin bad++; $display("FAIL vio_hold_pulses got=%0d want=0", pulses); end
    bus.i_from_hard = 1'b1;
    step();
    total++; if (bus.out_gpi !== 4'hA) begin bad++; $display("FAIL toggle_value got=%h want=a", bus.out_gpi); end
    total++; if (bus.out_sw_change !== 1'b0) begin bad++; $display("FAIL toggle_pulse got=%b want=0", bus.out_sw_change); end
    pulses = 0;
    bus.i_from_hard = 1'b0;
    bus.i_sw_vio    = 4'h5;
    repeat (4) begin step(); pulses += int'(bus.out_sw_change); end
    total++; if (pulses != 1) begin bad++; $display("FAIL multibit_pulses got=%0d want=1", pulses); end
    total++; if (bus.out_gpi !== 4'h5) begin bad++; $display("FAIL multibit_value got=%h want=5", bus.out_gpi); end
  endtask

  task automatic test_reset_mid_debounce();
    bus.i_from_hard = 1'b1;
    bus.i_sw = 4'h0;
    repeat (20) step();
    total++; if (bus.out_gpi !== 4'h0) begin bad++; $display("FAIL mid_settle got=%h want=0", bus.out_gpi); end
    bus.i_sw = 4'h3;
    repeat (5) step();
    #2 in_reset = 1'b0;
    step(); step();
    in_reset = 1'b1;
    for (int n = 1; n <= int'(SW_LAT); n++) begin
      step();
      total++; if (bus.out_gpi !== ((n >= int'(SW_LAT)) ? 4'h3 : 4'h0)) begin bad++; $display("FAIL mid_restart n=%0d got=%h", n, bus.out_gpi); end
    end
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_glitch_free();
    test_prescale();
    test_prescale_lower();
    test_random_pwm();
    test_debounce();
    test_source_select();
    test_reset_mid_debounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_led_sw_ctrl.md
Name: gpio_led_sw_ctrl

Overview:
Parametrised LED/switch I/O controller between the MicroBlaze GPIO word and the board pins. It drives NB_CH RGB LEDs with per-colour PWM brightness and glitch-free duty updates. Raw switches pass through a synchroniser and a debouncer. A hardware/debug (VIO) source select feeds the GPI word and flags any change with a one-cycle pulse. It replaces the direct gpo-to-LED and switch/VIO mux wiring in the top level and runs on clockdsp.

Parameters:
NB_CH, 4, number of RGB LEDs (3 colour bits each)
NB_PWM, 8, PWM duty/counter width
NB_PRESC, 16, prescaler width
NB_SW, 4, number of switches
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a switch change (>=1)

Ports:
clock  in  1  application clock (clockdsp)
in_reset  in  1  asynchronous, active-low reset
i_led_en  in  3*NB_CH  per-colour enable; bit 3*c+k = LED c, colour k (0=R, 1=G, 2=B)
i_duty  in  3*NB_CH*NB_PWM  per-colour duty; slice j = bits [j*NB_PWM +: NB_PWM], j=3*c+k
i_prescale  in  NB_PRESC  PWM tick divider; tick every i_prescale+1 cycles
i_sw  in  NB_SW  raw asynchronous board switches
i_sw_vio  in  NB_SW  debug switch value, synchronous to clock
i_from_hard  in  1  1 = use debounced i_sw; 0 = use i_sw_vio
out_leds_rgb  out  3*NB_CH  LED drive, same bit order as i_led_en
out_gpi  out  NB_SW  selected switch value to GPIO input
out_sw_change  out  1  one-cycle pulse when out_gpi changes

Behaviour:
- Reset (in_reset=0, asynchronous): prescaler, PWM counter, shadow duties, sync flops, debounce counters and stable values go to 0. out_leds_rgb=0, out_gpi=0, out_sw_change=0. On release, operation starts on the first rising edge.
- Prescaler: counts 0..i_prescale, then returns to 0. tick=1 when count==i_prescale. i_prescale=0 gives tick every cycle. If i_prescale is lowered below the current count, the count runs up to all-ones, wraps to 0, and resumes normally. No lockup.
- PWM counter (NB_PWM bits): increments on tick and wraps from all-ones to 0 (period = 2^NB_PWM ticks).
- Shadow duty: all i_duty slices are loaded together when tick is high and the PWM counter is all-ones, i.e. on wrap. A mid-period duty write never alters the current period.
- LED output is registered: out_leds_rgb[j] = i_led_en[j] & (shadow[j]=all-ones ? 1 : pwm_cnt < shadow[j]).
  - duty 0 gives a constant 0.
  - All-ones duty gives a constant 1.
  - Otherwise the LED is high for shadow[j] of 2^NB_PWM ticks.
  - An enable change appears 1 cycle later.
- Switch path, per bit:
  - 2-flop synchroniser, then debouncer.
  - The debounce counter increments while synced != stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with synced still differing, stable takes the synced value and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES produces no change.
- Source select and output register: out_gpi <= i_from_hard ? stable : i_sw_vio.
  - out_sw_change <= (next out_gpi != current out_gpi), so the pulse coincides with the first cycle the new value is visible.
  - A toggle of i_from_hard that changes the selected value also pulses.
  - Simultaneous multi-bit changes give a single pulse.
- Latency: a raw i_sw edge that is held steady appears on out_gpi DEBOUNCE_CYCLES+3 cycles after the first sampling edge. i_sw_vio appears 1 cycle later.
- Reset mid-debounce discards the partial count. Reset mid-PWM period restarts from count 0 with duty 0 until the first wrap.

Decomposition:
- Shared header gpio_io_pkg holds the colour-index localparams (R=0, G=1, B=2) and the defaults for NB_PWM and NB_PRESC.
- One sub-module, sw_debounce: per-bit synchroniser plus debouncer, parameter DEBOUNCE_CYCLES, instantiated NB_SW times with a generate loop.
- Prescaler, PWM counter and shadow duties stay in the top of the block.

Test Plan:
- Reset: hold in_reset=0 with i_sw=4'hF, i_led_en all 1, i_duty all 1s -> all outputs 0. After release, out_gpi stays 0 for DEBOUNCE_CYCLES+2 cycles.
- PWM: NB_PWM=4, i_prescale=0, LED0 R duty=4 -> high 4 of every 16 cycles. G duty=0 -> always 0. B duty=15 -> always 1.
- Glitch-free update: duty 4 -> 12 written at PWM count 2 -> current period still 4 high, next period 12 high. Enable cleared -> 0 after 1 cycle.
- Prescale: i_prescale=3, NB_PWM=4, duty=8 -> period 64 cycles, 32 cycles high.
- Debounce: DEBOUNCE_CYCLES=8, i_sw[0] high for 5 cycles then low -> no out_gpi change. Held high for 20 cycles -> out_gpi[0]=1 exactly 11 cycles after the first sampling edge, with out_sw_change high that cycle only.
- Source select: i_from_hard=0, i_sw_vio=4'hA -> out_gpi=4'hA next cycle with one pulse. Toggle back with stable=4'hA -> no pulse. Assert reset mid-debounce -> counter cleared and restarts from 0.
